// File: rtl/sram_pkg.sv
// Shared constants and encodings for the external asynchronous SRAM and
// its two-port arbiter.
package sram_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2,
      ST_TURN  = 2'd3
   } arb_state_e;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sram_pin_reg.sv
// SRAM pin registers: registered address and enables, tri-state write data,
// and read-data capture routed back to the port that issued the read.
module sram_pin_reg
   import sram_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_vld,
   input  logic              acc_we,
   input  logic              acc_port,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_data,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n,
   output logic [DATA_W-1:0] o_a_rdata,
   output logic              o_a_rvalid,
   output logic [DATA_W-1:0] o_b_rdata,
   output logic              o_b_rvalid
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_tag_q, rd_tag_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic              a_rvalid_q, a_rvalid_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              b_rvalid_q, b_rvalid_d;

   always_comb begin
      addr_d    = addr_q;
      we_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      wdata_d   = wdata_q;
      rd_pend_d = 1'b0;
      rd_tag_d  = rd_tag_q;
      if (acc_vld) begin
         addr_d    = acc_addr;
         we_n_d    = ~acc_we;
         oe_n_d    = acc_we;
         rd_pend_d = ~acc_we;
         rd_tag_d  = acc_port;
         if (acc_we) begin
            wdata_d = acc_wdata;
         end
      end

      // The read pin cycle ends at this edge: capture the bus for the tagged port.
      a_rvalid_d = rd_pend_q && (rd_tag_q == PORT_A);
      b_rvalid_d = rd_pend_q && (rd_tag_q == PORT_B);
      a_rdata_d  = a_rvalid_d ? io_sram_data : a_rdata_q;
      b_rdata_d  = b_rvalid_d ? io_sram_data : b_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         wdata_q    <= '0;
         rd_pend_q  <= 1'b0;
         rd_tag_q   <= PORT_A;
         a_rdata_q  <= '0;
         a_rvalid_q <= 1'b0;
         b_rdata_q  <= '0;
         b_rvalid_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         we_n_q     <= we_n_d;
         oe_n_q     <= oe_n_d;
         wdata_q    <= wdata_d;
         rd_pend_q  <= rd_pend_d;
         rd_tag_q   <= rd_tag_d;
         a_rdata_q  <= a_rdata_d;
         a_rvalid_q <= a_rvalid_d;
         b_rdata_q  <= b_rdata_d;
         b_rvalid_q <= b_rvalid_d;
      end
   end

   assign io_sram_data = we_n_q ? {DATA_W{1'bz}} : wdata_q;
   assign o_sram_addr  = addr_q;
   assign o_sram_we_n  = we_n_q;
   assign o_sram_oe_n  = oe_n_q;
   assign o_a_rdata    = a_rdata_q;
   assign o_a_rvalid   = a_rvalid_q;
   assign o_b_rdata    = b_rdata_q;
   assign o_b_rvalid   = b_rvalid_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for the shared asynchronous SRAM, with a
// per-owner burst cap and a one-cycle bubble on read-to-write turnaround.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W    = SRAM_ADDR_W,
   parameter int DATA_W    = SRAM_DATA_W,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_a_req,
   input  logic              i_a_we,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic              o_a_gnt,
   output logic [DATA_W-1:0] o_a_rdata,
   output logic              o_a_rvalid,
   input  logic              i_b_req,
   input  logic              i_b_we,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   output logic              o_b_gnt,
   output logic [DATA_W-1:0] o_b_rdata,
   output logic              o_b_rvalid,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_data,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic [CNT_W-1:0]  burst_q, burst_d;
   logic              last_rd_q, last_rd_d;

   logic              any_req;
   logic              win_port;
   logic              win_we;
   logic              gnt_ok;
   logic              a_gnt, b_gnt;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;

   always_comb begin
      any_req  = i_a_req | i_b_req;
      win_port = PORT_A;
      if (i_a_req && i_b_req) begin
         if (state_q == ST_IDLE) begin
            win_port = PORT_A;
         end else if (burst_q < BURST_CAP) begin
            win_port = owner_q;
         end else begin
            win_port = ~owner_q;
         end
      end else if (i_b_req) begin
         win_port = PORT_B;
      end
      win_we = (win_port == PORT_B) ? i_b_we : i_a_we;

      // A write right after a read grant is held off; that cycle is the bubble.
      gnt_ok = any_req && !(win_we && last_rd_q) && !rst;
      a_gnt  = gnt_ok && (win_port == PORT_A);
      b_gnt  = gnt_ok && (win_port == PORT_B);
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      burst_d   = burst_q;
      last_rd_d = 1'b0;
      if (!any_req) begin
         state_d = ST_IDLE;
         owner_d = PORT_A;
         burst_d = '0;
      end else if (gnt_ok) begin
         state_d   = (win_port == PORT_A) ? ST_OWN_A : ST_OWN_B;
         owner_d   = win_port;
         last_rd_d = ~win_we;
         if ((state_q != ST_IDLE) && (win_port == owner_q)) begin
            burst_d = (burst_q == BURST_CAP) ? burst_q : burst_q + CNT_W'(1);
         end else begin
            burst_d = CNT_W'(1);
         end
      end else begin
         // TURN records the bubble; owner and burst count carry across it.
         state_d = ST_TURN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= PORT_A;
         burst_q   <= '0;
         last_rd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         burst_q   <= burst_d;
         last_rd_q <= last_rd_d;
      end
   end

   assign acc_addr  = b_gnt ? i_b_addr : i_a_addr;
   assign acc_wdata = b_gnt ? i_b_wdata : i_a_wdata;
   assign o_a_gnt   = a_gnt;
   assign o_b_gnt   = b_gnt;

   sram_pin_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pin_reg (
      .clk          (clk),
      .rst          (rst),
      .acc_vld      (a_gnt | b_gnt),
      .acc_we       (win_we),
      .acc_port     (b_gnt ? PORT_B : PORT_A),
      .acc_addr     (acc_addr),
      .acc_wdata    (acc_wdata),
      .o_sram_addr  (o_sram_addr),
      .io_sram_data (io_sram_data),
      .o_sram_we_n  (o_sram_we_n),
      .o_sram_oe_n  (o_sram_oe_n),
      .o_a_rdata    (o_a_rdata),
      .o_a_rvalid   (o_a_rvalid),
      .o_b_rdata    (o_b_rdata),
      .o_b_rvalid   (o_b_rvalid)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an async SRAM model and a read-data
// scoreboard per port.
module tb_sram_arbiter;
   import sram_pkg::*;

   localparam int AW = 20;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          o_a_gnt, o_a_rvalid, o_b_gnt, o_b_rvalid;
   logic [DW-1:0] o_a_rdata, o_b_rdata;
   logic [AW-1:0] o_sram_addr;
   logic          o_sram_we_n, o_sram_oe_n;
   wire  [DW-1:0] io_sram_data;

   logic [DW-1:0] sram_mem [0:1023];
   logic [DW-1:0] ref_mem  [0:1023];
   logic [DW-1:0] qa [$];
   logic [DW-1:0] qb [$];
   logic [DW-1:0] exp_a, exp_b;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_a_req      (a_req),
      .i_a_we       (a_we),
      .i_a_addr     (a_addr),
      .i_a_wdata    (a_wdata),
      .o_a_gnt      (o_a_gnt),
      .o_a_rdata    (o_a_rdata),
      .o_a_rvalid   (o_a_rvalid),
      .i_b_req      (b_req),
      .i_b_we       (b_we),
      .i_b_addr     (b_addr),
      .i_b_wdata    (b_wdata),
      .o_b_gnt      (o_b_gnt),
      .o_b_rdata    (o_b_rdata),
      .o_b_rvalid   (o_b_rvalid),
      .o_sram_addr  (o_sram_addr),
      .io_sram_data (io_sram_data),
      .o_sram_we_n  (o_sram_we_n),
      .o_sram_oe_n  (o_sram_oe_n)
   );

   // Asynchronous SRAM model: drives the bus while read-enabled.
   assign io_sram_data = (!o_sram_oe_n && o_sram_we_n) ? sram_mem[o_sram_addr[9:0]] : 'z;
   always @(posedge clk) begin
      if (!o_sram_we_n) sram_mem[o_sram_addr[9:0]] <= io_sram_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are set just after a falling edge; check grants, update the model, advance.
   task automatic step(input string tag, input logic ea, input logic eb);
      #1;
      chk({tag, "_a_gnt"}, 32'(o_a_gnt), 32'(ea));
      chk({tag, "_b_gnt"}, 32'(o_b_gnt), 32'(eb));
      if (rst) begin
         qa.delete();
         qb.delete();
      end
      if (ea) begin
         if (a_we) ref_mem[a_addr[9:0]] = a_wdata;
         else      qa.push_back(ref_mem[a_addr[9:0]]);
      end
      if (eb) begin
         if (b_we) ref_mem[b_addr[9:0]] = b_wdata;
         else      qb.push_back(ref_mem[b_addr[9:0]]);
      end
      @(negedge clk);
   endtask

   task automatic pins(input string tag, input logic we_n, input logic oe_n);
      chk({tag, "_we_n"}, 32'(o_sram_we_n), 32'(we_n));
      chk({tag, "_oe_n"}, 32'(o_sram_oe_n), 32'(oe_n));
   endtask

   always @(negedge clk) begin
      if (o_a_rvalid) begin
         if (qa.size() == 0) chk("a_rvalid_unexpected", 32'(o_a_rvalid), 32'(0));
         else begin
            exp_a = qa.pop_front();
            chk("a_rdata", 32'(o_a_rdata), 32'(exp_a));
         end
      end
      if (o_b_rvalid) begin
         if (qb.size() == 0) chk("b_rvalid_unexpected", 32'(o_b_rvalid), 32'(0));
         else begin
            exp_b = qb.pop_front();
            chk("b_rdata", 32'(o_b_rdata), 32'(exp_b));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      @(negedge clk);

      // Requests during reset must not be granted.
      a_req = 1'b1; a_we = 1'b1; b_req = 1'b1;
      step("rst0", 1'b0, 1'b0);
      step("rst1", 1'b0, 1'b0);
      pins("rst", 1'b1, 1'b1);
      chk("rst_addr", 32'(o_sram_addr), 32'(0));
      chk("rst_a_rvalid", 32'(o_a_rvalid), 32'(0));
      chk("rst_b_rdata", 32'(o_b_rdata), 32'(0));
      rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
      step("idle0", 1'b0, 1'b0);

      // A-only write burst, one grant per cycle.
      a_req = 1'b1; a_we = 1'b1;
      for (int i = 0; i < 256; i++) begin
         a_addr = AW'(i); a_wdata = DW'(3 * i + 1);
         step("wr", 1'b1, 1'b0);
         pins("wr", 1'b0, 1'b1);
         chk("wr_addr", 32'(o_sram_addr), 32'(i));
         chk("wr_data", 32'(io_sram_data), 32'(3 * i + 1));
      end

      // B-only reads straight after the writes: no bubble.
      a_req = 1'b0; b_req = 1'b1; b_we = 1'b0;
      for (int i = 0; i < 256; i++) begin
         b_addr = AW'(i);
         step("rd", 1'b0, 1'b1);
         pins("rd", 1'b1, 1'b0);
         chk("rd_addr", 32'(o_sram_addr), 32'(i));
      end
      b_req = 1'b0;
      step("idle1", 1'b0, 1'b0);

      // Both reading continuously: 16/16 alternation starting with A.
      a_req = 1'b1; a_we = 1'b0; a_addr = AW'(10);
      b_req = 1'b1; b_we = 1'b0; b_addr = AW'(100);
      for (int k = 0; k < 48; k++) begin
         step("rr", ((k / 16) % 2) == 0, ((k / 16) % 2) != 0);
         if (((k / 16) % 2) == 0) a_addr = a_addr + 1'b1;
         else                     b_addr = b_addr + 1'b1;
         chk("rr_we_n", 32'(o_sram_we_n), 32'(1));
      end
      a_req = 1'b0; b_req = 1'b0;
      step("idle2", 1'b0, 1'b0);

      // A short A burst, an idle cycle, then contention gets a fresh window.
      a_req = 1'b1; a_addr = AW'(200);
      for (int k = 0; k < 5; k++) begin
         step("ar", 1'b1, 1'b0);
         a_addr = a_addr + 1'b1;
      end
      a_req = 1'b0;
      step("idle3", 1'b0, 1'b0);
      chk("idle3_we_n", 32'(o_sram_we_n), 32'(1));
      a_req = 1'b1; b_req = 1'b1; b_addr = AW'(150);
      for (int k = 0; k < 20; k++) begin
         step("fresh", k < 16, k >= 16);
         if (k < 16) a_addr = a_addr + 1'b1;
         else        b_addr = b_addr + 1'b1;
         chk("fresh_we_n", 32'(o_sram_we_n), 32'(1));
      end
      a_req = 1'b0; b_req = 1'b0;
      step("idle4", 1'b0, 1'b0);

      // Read then write: one dead cycle, write granted after it.
      b_req = 1'b1; b_we = 1'b0; b_addr = AW'(50);
      step("ta_brd", 1'b0, 1'b1);
      pins("ta_brd", 1'b1, 1'b0);
      b_req = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_addr = AW'(500); a_wdata = 16'hBEEF;
      step("ta_bubble", 1'b0, 1'b0);
      pins("ta_bubble", 1'b1, 1'b1);
      step("ta_awr", 1'b1, 1'b0);
      pins("ta_awr", 1'b0, 1'b1);
      chk("ta_addr", 32'(o_sram_addr), 32'(500));
      chk("ta_data", 32'(io_sram_data), 32'(16'hBEEF));
      a_req = 1'b0;
      step("idle5", 1'b0, 1'b0);

      // Write then read of the same word: back-to-back, data forwarded via SRAM.
      a_req = 1'b1; a_we = 1'b1; a_addr = AW'(600); a_wdata = 16'h1234;
      step("wr2", 1'b1, 1'b0);
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b0; b_addr = AW'(600);
      step("rd2", 1'b0, 1'b1);
      b_req = 1'b0;
      step("idle6", 1'b0, 1'b0);
      step("idle7", 1'b0, 1'b0);

      // Reset while a B read is in flight: dropped, pins reset, A wins after.
      b_req = 1'b1; b_we = 1'b0; b_addr = AW'(7);
      step("rst_rd", 1'b0, 1'b1);
      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = AW'(8);
      step("rst_hold", 1'b0, 1'b0);
      pins("rst_mid", 1'b1, 1'b1);
      chk("rst_mid_addr", 32'(o_sram_addr), 32'(0));
      chk("rst_mid_b_rvalid", 32'(o_b_rvalid), 32'(0));
      chk("rst_mid_b_rdata", 32'(o_b_rdata), 32'(0));
      chk("rst_mid_a_rdata", 32'(o_a_rdata), 32'(0));
      rst = 1'b0;
      step("post_rst", 1'b1, 1'b0);
      a_req = 1'b0; b_req = 1'b0;
      step("drain0", 1'b0, 1'b0);
      step("drain1", 1'b0, 1'b0);
      step("drain2", 1'b0, 1'b0);

      chk("qa_drained", 32'(qa.size()), 32'(0));
      chk("qb_drained", 32'(qb.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
